// File: rtl/vga_plot_arbiter.sv
// -----------------------------------------------------------------------------
// vga_plot_arbiter
//
// Shares the single vga_adapter plot port among several sprite drawers
// (index 0 = ball, 1 = left paddle, 2 = right paddle). Each drawer asks for a
// filled, single-colour rectangle. Requests are granted round-robin, and the
// granted rectangle is rasterized one pixel per clock, row-major. After the
// last pixel a one-cycle done pulse goes back to the owner. Erasing is an
// ordinary request drawn in the background colour.
//
// Parameters
//   NREQ        number of requesters
//   XMAX, YMAX  screen size; pixels at x >= XMAX or y >= YMAX are clipped
//               (the cycle is still spent, only the plot strobe is dropped)
//
// Ports
//   clk          system clock (CLOCK_50)
//   resetn       asynchronous, active-low reset
//   i_req        per-requester level request, held until that requester's done
//   i_req_x      packed top-left x,  requester i at [8i+7:8i]
//   i_req_y      packed top-left y,  requester i at [7i+6:7i]
//   i_req_w      packed width-1,     requester i at [4i+3:4i]
//   i_req_h      packed height-1,    requester i at [4i+3:4i]
//   i_req_colour packed RGB colour,  requester i at [3i+2:3i]
//   o_grant      one-hot owner of the job in progress, zero when idle
//   o_done       one-cycle pulse on the owner's bit after its last pixel
//   o_busy       high while a job is plotting or finishing
//   o_x, o_y     pixel coordinate to vga_adapter
//   o_colour     pixel colour to vga_adapter
//   o_plot       write strobe to vga_adapter
// -----------------------------------------------------------------------------
module vga_plot_arbiter #(
  parameter int NREQ = 3,
  parameter int XMAX = 160,
  parameter int YMAX = 120
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [NREQ-1:0]   i_req,
  input  logic [NREQ*8-1:0] i_req_x,
  input  logic [NREQ*7-1:0] i_req_y,
  input  logic [NREQ*4-1:0] i_req_w,
  input  logic [NREQ*4-1:0] i_req_h,
  input  logic [NREQ*3-1:0] i_req_colour,
  output logic [NREQ-1:0]   o_grant,
  output logic [NREQ-1:0]   o_done,
  output logic              o_busy,
  output logic [7:0]        o_x,
  output logic [6:0]        o_y,
  output logic [2:0]        o_colour,
  output logic              o_plot
);

  // Width of a requester index; at least one bit so NREQ = 1 still elaborates.
  localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_PLOT = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // ---------------------------------------------------------------------------
  // Registered state
  // ---------------------------------------------------------------------------
  logic [1:0]    r_state;
  logic [GW-1:0] r_g;       // owner of the current job
  logic [GW-1:0] r_rr;      // first index to consider at the next arbitration
  logic [7:0]    r_x0;
  logic [6:0]    r_y0;
  logic [3:0]    r_w;       // width-1
  logic [3:0]    r_h;       // height-1
  logic [2:0]    r_colour;
  logic [3:0]    r_cx;      // column within the rectangle
  logic [3:0]    r_cy;      // row within the rectangle

  // ---------------------------------------------------------------------------
  // Round-robin pick: first set request bit scanning rr, rr+1, ... mod NREQ.
  // The loop runs from the far end back toward rr so the closest hit is the
  // last assignment and therefore wins.
  // ---------------------------------------------------------------------------
  logic          w_any;
  logic [GW-1:0] w_pick;
  logic [GW-1:0] w_idx;

  always_comb begin
    // NOTE: every variable gets a default before any conditional assignment,
    // so no path leaves it unassigned and no latch is inferred.
    w_any  = 1'b0;
    w_pick = '0;
    w_idx  = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      w_idx = GW'((int'(r_rr) + k) % NREQ);
      if (i_req[w_idx]) begin
        w_any  = 1'b1;
        w_pick = w_idx;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Field select for the picked requester. A compare-per-requester mux keeps
  // every part-select index constant.
  // ---------------------------------------------------------------------------
  logic [7:0] w_sel_x;
  logic [6:0] w_sel_y;
  logic [3:0] w_sel_w;
  logic [3:0] w_sel_h;
  logic [2:0] w_sel_colour;

  always_comb begin
    w_sel_x      = '0;
    w_sel_y      = '0;
    w_sel_w      = '0;
    w_sel_h      = '0;
    w_sel_colour = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_pick == GW'(i)) begin
        w_sel_x      = i_req_x[8*i +: 8];
        w_sel_y      = i_req_y[7*i +: 7];
        w_sel_w      = i_req_w[4*i +: 4];
        w_sel_h      = i_req_h[4*i +: 4];
        w_sel_colour = i_req_colour[3*i +: 3];
      end
    end
  end

  // Next round-robin start: the requester after the one just served.
  logic [GW-1:0] w_rr_next;
  assign w_rr_next = GW'((int'(r_g) + 1) % NREQ);

  // End-of-row / end-of-job decode for the raster counters.
  logic w_row_end;
  logic w_job_end;
  assign w_row_end = (r_cx == r_w);
  assign w_job_end = w_row_end && (r_cy == r_h);

  // ---------------------------------------------------------------------------
  // Control FSM, owner and round-robin pointer
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetn) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (!resetn) begin
      r_state <= S_IDLE;
      r_g     <= '0;
      r_rr    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_g     <= w_pick;
            r_state <= S_PLOT;
          end
        end
        S_PLOT: begin
          if (w_job_end) begin
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          // No arbitration here: the owner drops its request on this edge,
          // so the next pick happens in the following IDLE cycle.
          r_rr    <= w_rr_next;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Latched rectangle. Fields are captured only at the grant edge, so later
  // changes on the request bus cannot disturb the job in progress.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetn) begin
    // NOTE: these holding registers are reset (unlike a plain storage array)
    // because they drive o_x/o_y/o_colour directly and must read zero.
    if (!resetn) begin
      r_x0     <= '0;
      r_y0     <= '0;
      r_w      <= '0;
      r_h      <= '0;
      r_colour <= '0;
    end else if (r_state == S_IDLE && w_any) begin
      r_x0     <= w_sel_x;
      r_y0     <= w_sel_y;
      r_w      <= w_sel_w;
      r_h      <= w_sel_h;
      r_colour <= w_sel_colour;
    end
  end

  // ---------------------------------------------------------------------------
  // Raster counters: cx sweeps a row, cy advances when cx wraps.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_cx <= '0;
      r_cy <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_cx <= '0;
            r_cy <= '0;
          end
        end
        S_PLOT: begin
          if (w_row_end) begin
            r_cx <= '0;
            if (!w_job_end) begin
              r_cy <= r_cy + 4'd1;
            end
          end else begin
            r_cx <= r_cx + 4'd1;
          end
        end
        default: begin
          r_cx <= r_cx;
          r_cy <= r_cy;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs, combinational from registered state.
  // The sums are one bit wider than the screen coordinate so a rectangle that
  // runs off the right/bottom edge is detected instead of wrapping on-screen.
  // ---------------------------------------------------------------------------
  logic [8:0] w_xsum;
  logic [7:0] w_ysum;
  logic       w_in_x;
  logic       w_in_y;
  logic       w_active;

  assign w_xsum   = {1'b0, r_x0} + {5'b0, r_cx};
  assign w_ysum   = {1'b0, r_y0} + {4'b0, r_cy};
  assign w_in_x   = int'(w_xsum) < XMAX;
  assign w_in_y   = int'(w_ysum) < YMAX;
  assign w_active = (r_state == S_PLOT) || (r_state == S_DONE);

  assign o_x      = w_xsum[7:0];
  assign o_y      = w_ysum[6:0];
  assign o_colour = r_colour;
  assign o_plot   = (r_state == S_PLOT) && w_in_x && w_in_y;
  assign o_busy   = w_active;

  always_comb begin
    o_grant = '0;
    o_done  = '0;
    if (w_active) begin
      o_grant[r_g] = 1'b1;
    end
    if (r_state == S_DONE) begin
      o_done[r_g] = 1'b1;
    end
  end

endmodule

// File: tb/tb_vga_plot_arbiter.sv
// -----------------------------------------------------------------------------
// tb_vga_plot_arbiter
//
// Directed and randomized bench for vga_plot_arbiter. Expected pixels, strobes
// and grant order come from a behavioural model: the winner is the first
// requesting index at or after the round-robin pointer, and each job is the
// row-major list of (x0+c, y0+r) pixels with a clip test against the screen.
// Outputs are sampled 1 ns after the rising edge; inputs change there too.
// -----------------------------------------------------------------------------
module tb_vga_plot_arbiter;

  localparam int NREQ = 3;
  localparam int XMAX = 160;
  localparam int YMAX = 120;

  logic              clk = 1'b0;
  logic              resetn = 1'b0;
  logic [NREQ-1:0]   req = '0;
  logic [NREQ*8-1:0] req_x = '0;
  logic [NREQ*7-1:0] req_y = '0;
  logic [NREQ*4-1:0] req_w = '0;
  logic [NREQ*4-1:0] req_h = '0;
  logic [NREQ*3-1:0] req_colour = '0;
  logic [NREQ-1:0]   grant;
  logic [NREQ-1:0]   done;
  logic              busy;
  logic [7:0]        x;
  logic [6:0]        y;
  logic [2:0]        colour;
  logic              plot;

  vga_plot_arbiter #(.NREQ(NREQ), .XMAX(XMAX), .YMAX(YMAX)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .i_req       (req),
    .i_req_x     (req_x),
    .i_req_y     (req_y),
    .i_req_w     (req_w),
    .i_req_h     (req_h),
    .i_req_colour(req_colour),
    .o_grant     (grant),
    .o_done      (done),
    .o_busy      (busy),
    .o_x         (x),
    .o_y         (y),
    .o_colour    (colour),
    .o_plot      (plot)
  );

  always #5 clk = ~clk;

  // Per-requester rectangle and "request again right after done" flag.
  logic [7:0] bx [NREQ];
  logic [6:0] by [NREQ];
  logic [3:0] bw [NREQ];
  logic [3:0] bh [NREQ];
  logic [2:0] bc [NREQ];
  bit         rereq [NREQ];

  int n_tests = 0;
  int n_fail  = 0;
  int m_rr    = 0;   // model round-robin pointer

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NREQ-1:0] oh(input int i);
    logic [NREQ-1:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  function automatic int pick(input logic [NREQ-1:0] r, input int rr);
    for (int k = 0; k < NREQ; k++) begin
      if (r[(rr + k) % NREQ]) return (rr + k) % NREQ;
    end
    return -1;
  endfunction

  task automatic pack();
    for (int i = 0; i < NREQ; i++) begin
      req_x[8*i +: 8]      = bx[i];
      req_y[7*i +: 7]      = by[i];
      req_w[4*i +: 4]      = bw[i];
      req_h[4*i +: 4]      = bh[i];
      req_colour[3*i +: 3] = bc[i];
    end
  endtask

  task automatic set_job(input int i, input int px, input int py, input int pw,
                         input int ph, input int pc);
    bx[i] = 8'(px);
    by[i] = 7'(py);
    bw[i] = 4'(pw);
    bh[i] = 4'(ph);
    bc[i] = 3'(pc);
    pack();
  endtask

  // Asserts reset, checks the asynchronous clear, then releases it 1 ns after
  // an edge with `r` on the request lines so the next edge arbitrates.
  task automatic do_reset(input logic [NREQ-1:0] r);
    resetn = 1'b0;
    #1;
    check("rst_busy",   32'(busy),   32'd0);
    check("rst_grant",  32'(grant),  32'd0);
    check("rst_done",   32'(done),   32'd0);
    check("rst_plot",   32'(plot),   32'd0);
    check("rst_x",      32'(x),      32'd0);
    check("rst_y",      32'(y),      32'd0);
    check("rst_colour", 32'(colour), 32'd0);
    m_rr = 0;
    @(posedge clk); #1;
    check("rst_hold_done", 32'(done), 32'd0);
    req    = r;
    resetn = 1'b1;
  endtask

  // Called during the IDLE cycle that samples the requests. Follows one whole
  // job: every pixel, the DONE cycle, and returns in the next IDLE cycle.
  // At pixel number change_at the owner's x field is rewritten to new_x.
  task automatic run_job(input int change_at, input logic [7:0] new_x);
    int who;
    int x0, y0, w, h, n, sx, sy;
    logic [2:0] col;
    logic exp_plot;
    who = pick(req, m_rr);
    if (who < 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL run_job: no request pending at arbitration");
      return;
    end
    x0  = int'(bx[who]);
    y0  = int'(by[who]);
    w   = int'(bw[who]);
    h   = int'(bh[who]);
    col = bc[who];
    check("idle_busy",  32'(busy),  32'd0);
    check("idle_grant", 32'(grant), 32'd0);
    check("idle_plot",  32'(plot),  32'd0);
    @(posedge clk); #1;
    n = 0;
    for (int r = 0; r <= h; r++) begin
      for (int c = 0; c <= w; c++) begin
        if (n == change_at) begin
          bx[who] = new_x;
          pack();
        end
        sx = x0 + c;
        sy = y0 + r;
        exp_plot = (sx < XMAX) && (sy < YMAX);
        check("pix_x",      32'(x),      32'(sx % 256));
        check("pix_y",      32'(y),      32'(sy % 128));
        check("pix_plot",   32'(plot),   32'(exp_plot));
        check("pix_colour", 32'(colour), 32'(col));
        check("pix_grant",  32'(grant),  32'(oh(who)));
        check("pix_busy",   32'(busy),   32'd1);
        check("pix_done",   32'(done),   32'd0);
        n++;
        @(posedge clk); #1;
      end
    end
    check("done_pulse", 32'(done),  32'(oh(who)));
    check("done_grant", 32'(grant), 32'(oh(who)));
    check("done_busy",  32'(busy),  32'd1);
    check("done_plot",  32'(plot),  32'd0);
    if (!rereq[who]) req[who] = 1'b0;
    m_rr = (who + 1) % NREQ;
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < NREQ; i++) begin
      set_job(i, 0, 0, 0, 0, 0);
      rereq[i] = 1'b0;
    end

    // Reset values, then idle with nothing requested.
    do_reset('0);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check("noreq_busy",  32'(busy),  32'd0);
      check("noreq_grant", 32'(grant), 32'd0);
      check("noreq_plot",  32'(plot),  32'd0);
    end

    // Single 4x4 ball at (50,60), white.
    set_job(0, 50, 60, 3, 3, 3'b111);
    req[0] = 1'b1;
    run_job(-1, 8'd0);

    // Clipping at the bottom-right corner.
    set_job(0, 158, 118, 3, 3, 3'b101);
    req[0] = 1'b1;
    run_job(-1, 8'd0);

    // 1x1 at the origin.
    set_job(0, 0, 0, 0, 0, 3'b010);
    req[0] = 1'b1;
    run_job(-1, 8'd0);

    // x field rewritten from 50 to 80 at pixel 5 of the job.
    set_job(0, 50, 60, 3, 3, 3'b110);
    req[0] = 1'b1;
    run_job(5, 8'd80);

    // Fairness, two requesters re-requesting: 0,1,0,1.
    set_job(0, 10, 10, 1, 1, 3'b001);
    set_job(1, 2, 40, 0, 3, 3'b100);
    rereq[0] = 1'b1;
    rereq[1] = 1'b1;
    do_reset(3'b011);
    for (int k = 0; k < 4; k++) run_job(-1, 8'd0);

    // Fairness, all three held: 0,1,2,0.
    set_job(2, 155, 30, 0, 3, 3'b011);
    rereq[2] = 1'b1;
    do_reset(3'b111);
    for (int k = 0; k < 4; k++) run_job(-1, 8'd0);

    // Reset in the middle of a 16x2 left-paddle job.
    for (int i = 0; i < NREQ; i++) rereq[i] = 1'b0;
    set_job(1, 20, 30, 15, 1, 3'b101);
    set_job(2, 100, 50, 1, 5, 3'b011);
    do_reset(3'b010);
    @(posedge clk); #1;
    check("mid_pix0_x", 32'(x), 32'd20);
    for (int k = 0; k < 7; k++) begin
      @(posedge clk); #1;
    end
    check("mid_pix7_x",    32'(x),     32'd27);
    check("mid_pix7_plot", 32'(plot),  32'd1);
    check("mid_pix7_grant", 32'(grant), 32'(oh(1)));
    req[2] = 1'b1;
    do_reset(3'b110);
    run_job(-1, 8'd0);   // rr = 0 with index 0 idle, so requester 1 first
    run_job(-1, 8'd0);   // then requester 2

    // Randomized traffic against the model.
    req = '0;
    for (int j = 0; j < 30; j++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!req[i] && $urandom_range(1, 0) == 1) begin
          set_job(i, int'($urandom_range(255, 0)), int'($urandom_range(127, 0)),
                  ($urandom_range(3, 0) == 0) ? int'($urandom_range(15, 0)) : int'($urandom_range(5, 0)),
                  ($urandom_range(3, 0) == 0) ? int'($urandom_range(15, 0)) : int'($urandom_range(5, 0)),
                  int'($urandom_range(7, 0)));
          req[i] = 1'b1;
        end
        rereq[i] = ($urandom_range(1, 0) == 1);
      end
      if (req == '0) begin
        set_job(0, int'($urandom_range(255, 0)), int'($urandom_range(127, 0)),
                int'($urandom_range(5, 0)), int'($urandom_range(5, 0)),
                int'($urandom_range(7, 0)));
        req[0] = 1'b1;
      end
      run_job(-1, 8'd0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
